// File: rtl/program_counter_stack.sv
// Program counter with increment, absolute jump and a hardware return-address
// stack for single-cycle CALL/RET; drives the shared bus when co is asserted.
module program_counter_stack #(
  parameter int                 WIDTH        = 8,
  parameter int                 STACK_DEPTH  = 4,
  parameter logic [WIDTH-1:0]   RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [WIDTH-1:0] bus,
  input  logic             ce,
  input  logic             co,
  input  logic             jmp,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             err
);

  localparam int PW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [PW-1:0] SP_FULL = PW'(STACK_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    sp_q, sp_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stack_q [STACK_DEPTH];
  logic             push;
  logic [IW-1:0]    push_idx, pop_idx;
  logic [WIDTH-1:0] pc_inc;

  assign pc_inc      = pc_q + 1'b1;
  assign stack_empty = (sp_q == '0);
  assign stack_full  = (sp_q == SP_FULL);
  assign push_idx    = IW'(sp_q);
  assign pop_idx     = IW'(sp_q - 1'b1);

  // With co and jmp/call together the load reads back our own pc via the bus.
  assign bus = co ? pc_q : {WIDTH{1'bz}};

  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    err_d = err_q;
    push  = 1'b0;
    if (ret) begin
      if (stack_empty) begin
        err_d = 1'b1;
      end else begin
        pc_d = stack_q[pop_idx];
        sp_d = sp_q - 1'b1;
      end
    end else if (call) begin
      if (stack_full) begin
        err_d = 1'b1;
      end else begin
        push = 1'b1;
        pc_d = bus;
        sp_d = sp_q + 1'b1;
      end
    end else if (jmp) begin
      pc_d = bus;
    end else if (ce) begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VECTOR;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Entries above the pointer are dead, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (!rst && push) stack_q[push_idx] <= pc_inc;
  end

  assign pc  = pc_q;
  assign err = err_q;

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed bench for program_counter_stack: count, wrap, jump, call/ret nesting,
// overflow/underflow, command priority and self-driven bus loads.
module tb_program_counter_stack;

  logic       clk = 1'b0;
  logic       rst, ce, co, jmp, call, ret;
  logic       bus_en;
  logic [7:0] bus_drv;
  wire  [7:0] bus;
  logic [7:0] pc;
  logic       stack_empty, stack_full, err;
  int         checks = 0;
  int         errors = 0;

  assign bus = bus_en ? bus_drv : 8'hzz;

  program_counter_stack #(.WIDTH(8), .STACK_DEPTH(4), .RESET_VECTOR(8'h00)) dut (
    .clk(clk), .rst(rst), .bus(bus), .ce(ce), .co(co), .jmp(jmp),
    .call(call), .ret(ret), .pc(pc), .stack_empty(stack_empty),
    .stack_full(stack_full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 0; ce = 0; co = 0; jmp = 0; call = 0; ret = 0; bus_en = 0; bus_drv = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick();
  endtask

  task automatic do_jmp(input logic [7:0] tgt);
    bus_en = 1; bus_drv = tgt; jmp = 1; tick();
  endtask

  task automatic do_call(input logic [7:0] tgt);
    bus_en = 1; bus_drv = tgt; call = 1; tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %h exp 00", pc); end
    checks++; if ({stack_empty, stack_full, err} !== 3'b100) begin errors++;
      $display("FAIL reset_flags got %b exp 100", {stack_empty, stack_full, err}); end
    bus_en = 1; bus_drv = 8'hAA; #1;
    checks++; if (bus !== 8'hAA) begin errors++; $display("FAIL reset_bus_released got %h exp aa", bus); end
    idle();
  endtask

  task automatic test_count();
    for (int i = 1; i <= 3; i++) begin
      ce = 1; tick();
      checks++; if (pc !== 8'(i)) begin errors++; $display("FAIL count_%0d got %h exp %h", i, pc, 8'(i)); end
    end
    co = 1; #1;
    checks++; if (bus !== 8'h03) begin errors++; $display("FAIL co_drive got %h exp 03", bus); end
    co = 0; bus_en = 1; bus_drv = 8'h5A; #1;
    checks++; if (bus !== 8'h5A) begin errors++; $display("FAIL co_release got %h exp 5a", bus); end
    idle();
  endtask

  task automatic test_wrap_jump();
    do_jmp(8'hFE);
    checks++; if (pc !== 8'hFE) begin errors++; $display("FAIL jmp_fe got %h exp fe", pc); end
    ce = 1; tick();
    checks++; if (pc !== 8'hFF) begin errors++; $display("FAIL inc_ff got %h exp ff", pc); end
    ce = 1; tick();
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL wrap_00 got %h exp 00", pc); end
    tick();
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL hold got %h exp 00", pc); end
  endtask

  task automatic test_call_ret();
    do_reset();
    do_jmp(8'h10);
    do_call(8'h40);
    checks++; if (pc !== 8'h40 || stack_empty !== 1'b0) begin errors++;
      $display("FAIL call_40 got pc %h empty %b exp 40 0", pc, stack_empty); end
    ce = 1; tick(); ce = 1; tick();
    checks++; if (pc !== 8'h42) begin errors++; $display("FAIL call_inc got %h exp 42", pc); end
    ret = 1; tick();
    checks++; if (pc !== 8'h11 || stack_empty !== 1'b1 || err !== 1'b0) begin errors++;
      $display("FAIL ret_11 got pc %h empty %b err %b exp 11 1 0", pc, stack_empty, err); end
  endtask

  task automatic test_nested_full();
    logic [7:0] exp_ret [4];
    exp_ret[0] = 8'h42; exp_ret[1] = 8'h32; exp_ret[2] = 8'h22; exp_ret[3] = 8'h02;
    do_reset();
    ce = 1; tick();
    do_call(8'h20); ce = 1; tick();
    do_call(8'h30); ce = 1; tick();
    do_call(8'h40); ce = 1; tick();
    checks++; if (pc !== 8'h41 || stack_full !== 1'b0) begin errors++;
      $display("FAIL pre_full got pc %h full %b exp 41 0", pc, stack_full); end
    do_call(8'h50);
    checks++; if (pc !== 8'h50 || stack_full !== 1'b1 || err !== 1'b0) begin errors++;
      $display("FAIL full got pc %h full %b err %b exp 50 1 0", pc, stack_full, err); end
    do_call(8'h60);
    checks++; if (pc !== 8'h50 || err !== 1'b1 || stack_full !== 1'b1) begin errors++;
      $display("FAIL overflow got pc %h err %b full %b exp 50 1 1", pc, err, stack_full); end
    for (int i = 0; i < 4; i++) begin
      ret = 1; tick();
      checks++; if (pc !== exp_ret[i]) begin errors++;
        $display("FAIL ret_%0d got %h exp %h", i, pc, exp_ret[i]); end
    end
    checks++; if (stack_empty !== 1'b1 || err !== 1'b1) begin errors++;
      $display("FAIL drained got empty %b err %b exp 1 1", stack_empty, err); end
  endtask

  task automatic test_underflow_priority();
    do_reset();
    ret = 1; tick();
    checks++; if (pc !== 8'h00 || err !== 1'b1 || stack_empty !== 1'b1) begin errors++;
      $display("FAIL underflow got pc %h err %b empty %b exp 00 1 1", pc, err, stack_empty); end
    ret = 1; jmp = 1; ce = 1; bus_en = 1; bus_drv = 8'h77; tick();
    checks++; if (pc !== 8'h00 || err !== 1'b1) begin errors++;
      $display("FAIL ret_wins got pc %h err %b exp 00 1", pc, err); end
    rst = 1; ce = 1; jmp = 1; bus_en = 1; bus_drv = 8'h99; tick();
    checks++; if (pc !== 8'h00 || err !== 1'b0) begin errors++;
      $display("FAIL rst_wins got pc %h err %b exp 00 0", pc, err); end
    ce = 1; tick();
    call = 1; jmp = 1; ce = 1; bus_en = 1; bus_drv = 8'h20; tick();
    checks++; if (pc !== 8'h20 || stack_empty !== 1'b0) begin errors++;
      $display("FAIL call_wins got pc %h empty %b exp 20 0", pc, stack_empty); end
    jmp = 1; ce = 1; bus_en = 1; bus_drv = 8'h70; tick();
    checks++; if (pc !== 8'h70) begin errors++; $display("FAIL jmp_over_ce got %h exp 70", pc); end
    ret = 1; tick();
    checks++; if (pc !== 8'h02) begin errors++; $display("FAIL call_wins_ret got %h exp 02", pc); end
  endtask

  task automatic test_self_load();
    do_reset();
    do_jmp(8'h33);
    co = 1; jmp = 1; #1;
    checks++; if (bus !== 8'h33) begin errors++; $display("FAIL self_bus_pre got %h exp 33", bus); end
    @(posedge clk); #1;
    checks++; if (pc !== 8'h33 || bus !== 8'h33) begin errors++;
      $display("FAIL self_jmp got pc %h bus %h exp 33 33", pc, bus); end
    jmp = 0; call = 1; tick();
    checks++; if (pc !== 8'h33 || stack_empty !== 1'b0) begin errors++;
      $display("FAIL self_call got pc %h empty %b exp 33 0", pc, stack_empty); end
    ret = 1; tick();
    checks++; if (pc !== 8'h34) begin errors++; $display("FAIL self_call_ret got %h exp 34", pc); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_jmp(8'h05);
    do_call(8'h80);
    ret = 1; tick();
    checks++; if (pc !== 8'h06 || stack_empty !== 1'b1) begin errors++;
      $display("FAIL b2b_ret got pc %h empty %b exp 06 1", pc, stack_empty); end
    do_call(8'h90);
    do_call(8'hA0);
    rst = 1; tick();
    checks++; if (pc !== 8'h00 || stack_empty !== 1'b1 || stack_full !== 1'b0) begin errors++;
      $display("FAIL mid_rst got pc %h empty %b full %b exp 00 1 0", pc, stack_empty, stack_full); end
  endtask

  initial begin
    idle();
    #2;
    test_reset();
    test_count();
    test_wrap_jump();
    test_call_ret();
    test_nested_full();
    test_underflow_priority();
    test_self_load();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_counter_stack.md
# program_counter_stack

Parametrised successor to the 8-bit program counter: a WIDTH-bit instruction pointer with increment, absolute jump from the shared bus, and a hardware return-address stack for single-instruction CALL/RET. It sits on the CPU's shared tri-state bus and is driven by the control-word decoder: ce, co and jmp as before, plus call and ret. It reports stack status and a sticky error flag to the control unit.

## Interface
Parameters:
- WIDTH, 8, width of PC, bus and stack entries
- STACK_DEPTH, 4, number of return-address entries (≥1)
- RESET_VECTOR, 0, PC value after reset

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- bus  inout  WIDTH  shared data bus; driven with pc when co=1, else high-Z
- ce  input  1  count enable: pc ← pc+1
- co  input  1  counter out: drive pc onto bus
- jmp  input  1  load pc from bus
- call  input  1  push return address, load pc from bus
- ret  input  1  pop top of stack into pc
- pc  output  WIDTH  current PC register (debug/monitor)
- stack_empty  output  1  no entries held
- stack_full  output  1  STACK_DEPTH entries held
- err  output  1  sticky: stack overflow or underflow occurred

## Operation
- Reset (rst=1 at rising edge): pc ← RESET_VECTOR, stack pointer ← 0, err ← 0. rst has priority over all other inputs. After reset: stack_empty=1, stack_full=0, err=0, and bus is high-Z unless co=1.
- Command priority at each edge, highest first: rst > ret > call > jmp > ce. Only the highest asserted command executes; lower ones are ignored that cycle.
- ret: if not empty, pc ← stack[top], pointer decrements. If empty, pc holds, the pointer is unchanged, and err ← 1.
- call: if not full, stack[top] ← pc+1 (mod 2^WIDTH), the pointer increments, and pc ← bus. If full, there is no push and no load, pc holds, and err ← 1.
- jmp: pc ← bus. The stack is untouched.
- ce: pc ← pc+1 (mod 2^WIDTH). 2^WIDTH−1 wraps to 0.
- No command: pc holds.
- Loads read whatever is on bus. With co=1 and jmp/call in the same cycle, the load value is pc itself (self-driven bus). This is legal and deterministic.
- err is cleared only by rst.
- Stack storage is a register array indexed by the pointer. The pointer is $clog2(STACK_DEPTH+1) bits and ranges 0..STACK_DEPTH.

## Timing
- Bus output is combinational from co and the pc register. When co rises, pc appears on bus in the same cycle with no clock latency.
- All register updates (pc, stack, pointer, err) take effect at the rising edge where the command is sampled. The new pc is visible immediately after that edge.
- stack_empty and stack_full decode combinationally from the pointer, so they update in the same cycle as the pointer.
- Single-cycle throughput: back-to-back call/ret on consecutive edges is supported. A ret on the edge after a call returns to the pushed address.
- rst asserted mid-sequence discards all stack contents at that edge. Commands asserted in the same cycle as rst are ignored.

## Test plan
- Reset/count: rst for 1 cycle, then ce=1 for 3 edges -> pc=0,1,2,3. With co=1, bus reads 8'h03. With co=0, bus is high-Z (TB can drive it).
- Wrap/jump: bus=8'hFE, jmp=1 for one edge, then ce for 2 edges -> pc=FE, FF, 00.
- Call/return: pc=8'h10, bus=8'h40, call -> pc=40, stack_empty=0. Then ce twice -> 42. Then ret -> pc=11, stack_empty=1.
- Nested to full: STACK_DEPTH=4, four calls from pcs 01/21/31/41 to targets 20/30/40/50 -> stack_full=1. A fifth call -> pc stays 50, err=1. Four rets -> pc=42,32,22,02.
- Underflow/priority: after reset, ret -> pc stays 00, err=1. With ret+jmp+ce together, ret wins and err remains 1. rst -> err=0.
- Self-load: pc=8'h33, co=1, jmp=1 -> pc stays 33, bus=33 throughout.
